// File: rtl/reg_scoreboard_pkg.sv
// Shared types and sizing for the pending-write scoreboard.
package reg_scoreboard_pkg;

  localparam int SB_CNT_W        = 2;
  localparam int SB_MAX_INFLIGHT = 4;
  localparam int SB_NUM_REGS     = 32;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] rd;
  } sb_issue_t;

  // Writes to x0, or non-writing instructions, never occupy a counter.
  function automatic logic sb_is_tracked(input sb_issue_t i);
    return i.we && (i.rd != 5'd0);
  endfunction

endpackage

// File: rtl/reg_pend_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module reg_pend_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o,
  output logic at_max_o,
  output logic unf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_inc, do_dec;

  assign nonzero_o = |cnt_q;
  assign at_max_o  = &cnt_q;
  assign do_inc    = inc_i & ~at_max_o;
  assign do_dec    = dec_i & nonzero_o;
  assign unf_o     = dec_i & ~nonzero_o;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_inc, do_dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: issue marks rd pending, WB commit
// clears it, decode queries rs1/rs2 to stall on outstanding writes.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W        = SB_CNT_W,
  parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic          issue_we,
  input  logic [4:0]    issue_rd,
  output logic          issue_ready,
  input  logic          commit_valid,
  input  logic [4:0]    commit_rd,
  input  logic [4:0]    rs1_s,
  input  logic [4:0]    rs2_s,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          sb_stall,
  output logic          full,
  output logic [IW-1:0] inflight,
  output logic          underflow_err
);

  sb_issue_t                  iss;
  logic [SB_NUM_REGS-1:0]     nonzero, at_max, unf;
  logic                       untracked, tracked, commit_ok;
  logic [IW-1:0]              inflight_q, inflight_d;
  logic                       err_q, err_d;

  assign iss = '{valid: issue_valid, we: issue_we, rd: issue_rd};

  // x0 has no counter; its status bits are constant.
  assign nonzero[0] = 1'b0;
  assign at_max[0]  = 1'b0;
  assign unf[0]     = 1'b0;

  for (genvar r = 1; r < SB_NUM_REGS; r++) begin : g_reg
    reg_pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (tracked && (iss.rd == 5'(r))),
      .dec_i     (commit_valid && (commit_rd == 5'(r))),
      .nonzero_o (nonzero[r]),
      .at_max_o  (at_max[r]),
      .unf_o     (unf[r])
    );
  end

  assign full        = (inflight_q == IW'(MAX_INFLIGHT));
  assign untracked   = ~sb_is_tracked(iss);
  assign issue_ready = ~full & (untracked | ~at_max[iss.rd]);
  assign tracked     = iss.valid & issue_ready & ~untracked;
  assign commit_ok   = commit_valid & nonzero[commit_rd];

  // Busy reads only registered counters; a same-cycle commit is covered by WB forwarding.
  assign rs1_busy      = nonzero[rs1_s];
  assign rs2_busy      = nonzero[rs2_s];
  assign sb_stall      = rs1_busy | rs2_busy;
  assign inflight      = inflight_q;
  assign underflow_err = err_q;

  always_comb begin
    inflight_d = inflight_q;
    if (tracked && !commit_ok)      inflight_d = inflight_q + IW'(1);
    else if (!tracked && commit_ok) inflight_d = inflight_q - IW'(1);
  end

  assign err_d = err_q | (|unf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench: stimulus queues expected outputs, a negedge monitor compares.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_we, commit_valid;
  logic [4:0] issue_rd, commit_rd, rs1_s, rs2_s;
  logic       issue_ready, rs1_busy, rs2_busy, sb_stall, full, underflow_err;
  logic [2:0] inflight;

  typedef struct {
    string      name;
    logic [8:0] vec;  // {ready, rs1_busy, rs2_busy, stall, full, inflight[2:0], underflow_err}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  reg_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_we      (issue_we),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .commit_valid  (commit_valid),
    .commit_rd     (commit_rd),
    .rs1_s         (rs1_s),
    .rs2_s         (rs2_s),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .sb_stall      (sb_stall),
    .full          (full),
    .inflight      (inflight),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {issue_ready, rs1_busy, rs2_busy, sb_stall, full, inflight, underflow_err};
      n_checks++;
      if (act === e.vec) n_pass++;
      else $display("FAIL %s: got rdy/b1/b2/stall/full/inf/uerr=%b required %b",
                    e.name, act, e.vec);
    end
  end

  // Set this cycle's inputs just after the rising edge.
  task automatic cyc(input logic iv, input logic we, input logic [4:0] rd,
                     input logic cv, input logic [4:0] crd,
                     input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    issue_valid = iv; issue_we = we; issue_rd = rd;
    commit_valid = cv; commit_rd = crd;
    rs1_s = r1; rs2_s = r2;
  endtask

  task automatic chk(input string nm, input logic rdy, input logic b1, input logic b2,
                     input logic fl, input logic [2:0] inf, input logic ue);
    exp_t e;
    e.name = nm;
    e.vec  = {rdy, b1, b2, b1 | b2, fl, inf, ue};
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 0; issue_we = 0; issue_rd = 0;
    commit_valid = 0; commit_rd = 0; rs1_s = 0; rs2_s = 0;
    chk("reset_init", 1, 0, 0, 0, 3'd0, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // RAW hazard on x5
    cyc(1, 1, 5, 0, 0, 5, 0);  chk("raw_before", 1, 0, 0, 0, 3'd0, 0);
    cyc(0, 0, 0, 0, 0, 5, 0);  chk("raw_busy", 1, 1, 0, 0, 3'd1, 0);
    cyc(0, 0, 0, 1, 5, 5, 0);  chk("raw_commit_cycle", 1, 1, 0, 0, 3'd1, 0);
    cyc(0, 0, 0, 0, 0, 5, 0);  chk("raw_cleared", 1, 0, 0, 0, 3'd0, 0);

    // Saturate x7, then fill with x8
    cyc(1, 1, 7, 0, 0, 7, 0);
    cyc(1, 1, 7, 0, 0, 7, 0);
    cyc(1, 1, 7, 0, 0, 7, 0);  chk("sat_cnt2", 1, 1, 0, 0, 3'd2, 0);
    cyc(1, 1, 7, 0, 0, 7, 8);  chk("sat_blocked", 0, 1, 0, 0, 3'd3, 0);
    cyc(1, 1, 8, 0, 0, 7, 8);  chk("sat_other_rd_ok", 1, 1, 0, 0, 3'd3, 0);
    cyc(1, 1, 9, 0, 0, 7, 8);  chk("full_blocks", 0, 1, 1, 1, 3'd4, 0);
    cyc(1, 1, 9, 1, 7, 7, 8);  chk("full_commit_cycle", 0, 1, 1, 1, 3'd4, 0);
    cyc(0, 0, 0, 1, 7, 7, 9);  chk("drain_3", 1, 1, 0, 0, 3'd3, 0);
    cyc(0, 0, 0, 1, 7, 7, 8);  chk("drain_2", 1, 1, 1, 0, 3'd2, 0);
    cyc(0, 0, 0, 1, 8, 7, 8);  chk("drain_1", 1, 0, 1, 0, 3'd1, 0);
    cyc(0, 0, 0, 0, 0, 7, 8);  chk("drain_0", 1, 0, 0, 0, 3'd0, 0);

    // Same-rd issue+commit, then different rds
    cyc(1, 1, 3, 0, 0, 3, 0);
    cyc(1, 1, 3, 1, 3, 3, 0);  chk("same_rd_cycle", 1, 1, 0, 0, 3'd1, 0);
    cyc(0, 0, 0, 0, 0, 3, 0);  chk("same_rd_after", 1, 1, 0, 0, 3'd1, 0);
    cyc(1, 1, 10, 1, 3, 3, 10); chk("diff_rd_cycle", 1, 1, 0, 0, 3'd1, 0);
    cyc(0, 0, 0, 0, 0, 3, 10); chk("diff_rd_after", 1, 0, 1, 0, 3'd1, 0);
    cyc(0, 0, 0, 1, 10, 3, 10);
    cyc(0, 0, 0, 0, 0, 3, 10); chk("diff_rd_drained", 1, 0, 0, 0, 3'd0, 0);

    // x0 and untracked issues, commit to x0
    cyc(1, 1, 0, 0, 0, 0, 4);
    cyc(1, 0, 4, 0, 0, 0, 4);  chk("x0_issue", 1, 0, 0, 0, 3'd0, 0);
    cyc(0, 0, 0, 1, 0, 0, 4);  chk("untracked_issue", 1, 0, 0, 0, 3'd0, 0);
    cyc(0, 0, 0, 0, 0, 0, 4);  chk("x0_commit_no_err", 1, 0, 0, 0, 3'd0, 0);

    // Underflow, sticky through valid traffic
    cyc(0, 0, 0, 1, 9, 9, 0);  chk("unf_same_cycle", 1, 0, 0, 0, 3'd0, 0);
    cyc(1, 1, 5, 0, 0, 5, 9);  chk("unf_set", 1, 0, 0, 0, 3'd0, 1);
    cyc(0, 0, 0, 1, 5, 5, 9);  chk("unf_sticky_busy", 1, 1, 0, 0, 3'd1, 1);
    cyc(1, 1, 5, 0, 0, 5, 9);  chk("unf_sticky_idle", 1, 0, 0, 0, 3'd0, 1);
    cyc(0, 0, 0, 0, 0, 5, 9);  chk("pre_reset_busy", 1, 1, 0, 0, 3'd1, 1);

    // Asynchronous reset mid-run clears everything before any clock edge
    @(posedge clk); #2 rst_n = 1'b0;
    chk("reset_midrun", 1, 0, 0, 0, 3'd0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 5, 9);  chk("post_reset", 1, 0, 0, 0, 3'd0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
